// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the single-digit BCD up/down counter.
// Holds the digit width, the legal digit range and the step-operation decode.
package bcd_counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_op_e;

  // Both enables together cancel out, so neither direction has priority.
  function automatic step_op_e decode_op(input logic inc, input logic dec);
    step_op_e op;
    op = STEP_HOLD;
    if (inc && !dec) begin
      op = STEP_INC;
    end else if (dec && !inc) begin
      op = STEP_DEC;
    end
    return op;
  endfunction

  function automatic logic is_legal(input bcd_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational next-digit function: +1/-1 with 9<->0 wrap, hold when idle.
// An illegal code (10..15) recovers to 0 on any enabled step and is kept on hold.
module bcd_digit_step
  import bcd_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] next_digit
);

  step_op_e w_op;

  assign w_op = decode_op(inc, dec);

  always_comb begin
    next_digit = digit;
    if (w_op != STEP_HOLD) begin
      if (!is_legal(digit)) begin
        next_digit = BCD_MIN;
      end else if (w_op == STEP_INC) begin
        next_digit = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        next_digit = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Single BCD digit up/down counter; count updates one clk edge after up/down.
// Asynchronous active-high reset clears the digit immediately.
module bcd_counter
  import bcd_counter_pkg::*;
(
  output logic [DIGIT_W-1:0] count,
  input  logic               up,
  input  logic               down,
  input  logic               clk,
  input  logic               reset
);

  logic [DIGIT_W-1:0] w_next;

  bcd_digit_step u_step (
    .digit      (count),
    .inc        (up),
    .dec        (down),
    .next_digit (w_next)
  );

  // count is the state register itself, so no logic sits between it and the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= BCD_MIN;
    end else begin
      count <= w_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed scenarios plus randomized
// up/down/reset traffic against a modulo-10 reference model on every edge.
module tb_bcd_counter;

  logic [3:0] count;
  logic       up;
  logic       down;
  logic       clk;
  logic       reset;

  int n_cmp;
  int n_fail;
  int m_count;
  bit mon_en;

  bcd_counter dut (
    .count (count),
    .up    (up),
    .down  (down),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a digit in 0..9 that moves by +1/-1 modulo 10, cleared by reset.
  task automatic monitor();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_count = 0;
      end else if (up && !down) begin
        m_count = (m_count + 1) % 10;
      end else if (down && !up) begin
        m_count = (m_count + 9) % 10;
      end
      #1;
      if (mon_en) begin
        n_cmp++;
        if (count !== m_count[3:0]) begin
          n_fail++;
          $display("FAIL model_edge t=%0t: count=%0d expected=%0d", $time, count, m_count);
        end
        n_cmp++;
        if ($isunknown(count) || count > 4'd9) begin
          n_fail++;
          $display("FAIL range t=%0t: count=%0d expected 0..9", $time, count);
        end
      end
    end
  endtask

  task automatic step(input bit u, input bit d);
    @(negedge clk);
    up   = u;
    down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up    = 1'b1;
    down  = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: count=%0d expected=0", count);
    end
    @(negedge clk);
    reset = 1'b0;
    up    = 1'b0;
    mon_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (count !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_release_count: count=%0d expected=2", count);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d expected=0 before next edge", count);
    end
    reset = 1'b0;
    up    = 1'b0;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (count !== 4'((i + 1) % 10)) begin
        n_fail++;
        $display("FAIL count_up[%0d]: count=%0d expected=%0d", i, count, (i + 1) % 10);
      end
    end
    n_cmp++;
    if (count !== 4'd2) begin
      n_fail++;
      $display("FAIL count_up_final: count=%0d expected=2", count);
    end
  endtask

  task automatic test_count_down();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      n_cmp++;
      if (count !== 4'((2 - (i + 1) + 20) % 10)) begin
        n_fail++;
        $display("FAIL count_down[%0d]: count=%0d expected=%0d", i, count, (2 - (i + 1) + 20) % 10);
      end
    end
    n_cmp++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL count_down_final: count=%0d expected=0", count);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (count !== 4'd7) begin
        n_fail++;
        $display("FAIL hold_idle[%0d]: count=%0d expected=7", i, count);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (count !== 4'd7) begin
        n_fail++;
        $display("FAIL hold_both[%0d]: count=%0d expected=7", i, count);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_run_setup: count=%0d expected=5", count);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_run_reset: count=%0d expected=0", count);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_run_after_release: count=%0d expected=1", count);
    end
  endtask

  task automatic test_random();
    int exp_v;
    exp_v = int'(count);
    for (int i = 0; i < 400; i++) begin
      bit u;
      bit d;
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      @(negedge clk);
      up   = u;
      down = d;
      if ($urandom_range(0, 29) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_v = 0;
      end
      @(posedge clk);
      #1;
      if (u && !d) exp_v = (exp_v + 1) % 10;
      else if (d && !u) exp_v = (exp_v + 9) % 10;
      n_cmp++;
      if (count !== 4'(exp_v)) begin
        n_fail++;
        $display("FAIL random[%0d] u=%0b d=%0b: count=%0d expected=%0d", i, u, d, count, exp_v);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    m_count = 0;
    mon_en  = 1'b0;
    up      = 1'b0;
    down    = 1'b0;
    reset   = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_count_up();
    test_count_down();
    test_hold();
    test_reset_mid_run();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameters: none; the counter is fixed at one 4-bit BCD digit.
REQ-002 Port declaration order SHALL be count, up, down, clk, reset, so positional instantiation works.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 count  output  4  current BCD digit, 0..9, driven directly from a register.
REQ-006 up  input  1  count-up enable, sampled on the rising edge of clk.
REQ-007 down  input  1  count-down enable, sampled on the rising edge of clk.

Function
REQ-008 Only one clock domain SHALL exist: clk, with reset asynchronous.
REQ-009 up=1, down=0: count SHALL increment by 1 on each rising edge of clk.
REQ-010 Increment wrap: count 9 SHALL go to 0 on the next increment edge.
REQ-011 up=0, down=1: count SHALL decrement by 1 on each rising edge of clk.
REQ-012 Decrement wrap: count 0 SHALL go to 9 on the next decrement edge.
REQ-013 up=0, down=0: count SHALL hold its value.
REQ-014 up=1, down=1 together: count SHALL hold its value; up has no priority over down.
REQ-015 Latency: count SHALL show the new value one clock edge after enables are sampled; there is no combinational path from up/down to count.
REQ-016 Codes 10..15 SHALL never be produced in normal operation.
REQ-017 If count ever holds 10..15, any enabled step (up or down) SHALL load 0; hold SHALL keep the illegal value.
REQ-018 count SHALL change only on a rising edge of clk or on assertion of reset.

Reset
REQ-019 Asserting reset SHALL force count to 0 immediately, without waiting for a clock edge.
REQ-020 While reset is high, count SHALL stay 0 regardless of clk, up and down.
REQ-021 Reset asserted mid-count SHALL abort the count and give count=0 at once.
REQ-022 After reset deasserts, the first rising edge of clk SHALL apply the current up/down values normally.

Structure
REQ-023 A shared package SHALL hold: BCD_MAX = 4'd9, BCD_MIN = 4'd0, and the digit width constant (4).
REQ-024 One sub-module SHALL be used: bcd_digit_step, a combinational next-digit function (inputs: digit, inc, dec; output: next digit, including wrap and illegal-code handling).
REQ-025 The top level SHALL contain only the register with async reset and one instance of bcd_digit_step.

Verification
REQ-026 Reset: assert reset for one clock period at 10-unit clock -> count=0; assert reset between edges -> count=0 at once, before the next edge.
REQ-027 Count up: from 0, up=1 for 12 edges -> sequence 1..9,0,1,2; final count=2.
REQ-028 Count down: from 2, down=1 for 12 edges -> sequence 1,0,9,8..1,0; final count=0.
REQ-029 Hold: up=down=0 for 5 edges at count=7 -> stays 7; up=down=1 for 5 edges -> stays 7.
REQ-030 Reset mid-run: reset pulse while counting up at count=5 -> count=0 immediately; next up edge after release -> 1.
REQ-031 All checks: count SHALL never leave 0..9 after reset, and a self-checking model SHALL compare count on every rising edge of clk.
